// File: rtl/sym_align_err_cnt_if.sv
// Symbol stream bundle for the alignment / error-count stage.
// The producer side (slicer + LFSR) uses master; the aligner uses slave.
interface sym_align_err_cnt_if #(
  parameter int DELAY_W = 7,
  parameter int CNT_W   = 11
);
  logic               clk_en;
  logic [1:0]         tx_data;
  logic [1:0]         rx_data;
  logic [DELAY_W-1:0] delay;
  logic               locked;
  logic [CNT_W-1:0]   err_count;
  logic               err_valid;
  logic               search_wrap;
  logic [1:0]         tx_data_aligned;

  modport master (
    output clk_en, tx_data, rx_data,
    input  delay, locked, err_count, err_valid, search_wrap, tx_data_aligned
  );

  modport slave (
    input  clk_en, tx_data, rx_data,
    output delay, locked, err_count, err_valid, search_wrap, tx_data_aligned
  );
endinterface

// File: rtl/sym_align_err_cnt.sv
// Finds the TX->RX symbol delay by windowed error search, locks on it and
// keeps reporting per-window symbol error counts while locked.
module sym_align_err_cnt #(
  parameter int MAX_DELAY     = 127,
  parameter int DELAY_W       = 7,
  parameter int WIN_LEN       = 1024,
  parameter int CNT_W         = 11,
  parameter int LOCK_THRESH   = 0,
  parameter int UNLOCK_THRESH = 32,
  parameter int LOSS_WINDOWS  = 2
) (
  input logic              clk,
  input logic              reset,
  sym_align_err_cnt_if.slave bus
);
  localparam int BAD_W = (LOSS_WINDOWS < 2) ? 1 : $clog2(LOSS_WINDOWS + 1);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [1:0]         aligned_q;
  logic [1:0]         line_q [MAX_DELAY];

  logic [1:0]         tap;
  logic [DELAY_W-1:0] tap_idx;
  logic               err_evt;
  logic               win_end;
  logic [CNT_W-1:0]   win_sum;

  // line_q[0] is the TX symbol from one enable ago, so delay 0 taps the input
  always_comb begin
    tap_idx = delay_q - DELAY_W'(1);
    tap     = bus.tx_data;
    if (delay_q != '0) begin
      tap = line_q[tap_idx];
    end
  end

  assign err_evt = (tap != bus.rx_data);
  assign win_sum = acc_q + CNT_W'(err_evt);
  assign win_end = (win_q == CNT_W'(WIN_LEN - 1));

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    fill_d      = fill_q;
    win_d       = win_q;
    acc_d       = acc_q;
    err_count_d = err_count_q;
    bad_d       = bad_q;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        FILL: begin
          if (fill_q == DELAY_W'(MAX_DELAY - 1)) begin
            state_d = SEARCH;
            delay_d = '0;
            fill_d  = '0;
            win_d   = '0;
            acc_d   = '0;
          end else begin
            fill_d = fill_q + DELAY_W'(1);
          end
        end
        SEARCH, LOCKED: begin
          if (win_end) begin
            // The last symbol's error is folded in and the next window starts at once
            win_d       = '0;
            acc_d       = '0;
            err_count_d = win_sum;
            valid_d     = 1'b1;
            if (state_q == SEARCH) begin
              if (win_sum <= CNT_W'(LOCK_THRESH)) begin
                state_d = LOCKED;
                bad_d   = '0;
              end else if (delay_q == DELAY_W'(MAX_DELAY)) begin
                delay_d = '0;
                wrap_d  = 1'b1;
              end else begin
                delay_d = delay_q + DELAY_W'(1);
              end
            end else if (win_sum > CNT_W'(UNLOCK_THRESH)) begin
              if (bad_q == BAD_W'(LOSS_WINDOWS - 1)) begin
                state_d = SEARCH;
                delay_d = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + BAD_W'(1);
              end
            end else begin
              bad_d = '0;
            end
          end else begin
            win_d = win_q + CNT_W'(1);
            acc_d = win_sum;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Pulses are refreshed every clock so they last one cycle even if clk_en drops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      delay_q     <= '0;
      fill_q      <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      err_count_q <= '0;
      bad_q       <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      aligned_q   <= '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      err_count_q <= err_count_d;
      bad_q       <= bad_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      if (bus.clk_en) begin
        aligned_q <= tap;
        line_q[0] <= bus.tx_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
          line_q[i] <= line_q[i-1];
        end
      end
    end
  end

  assign bus.delay           = delay_q;
  assign bus.locked          = (state_q == LOCKED);
  assign bus.err_count       = err_count_q;
  assign bus.err_valid       = valid_q;
  assign bus.search_wrap     = wrap_q;
  assign bus.tx_data_aligned = aligned_q;
endmodule

// File: tb/tb_sym_align_err_cnt.sv
// Bench for sym_align_err_cnt: a vector table for the first cycles, then
// random symbol streams scored against an enable-indexed reference model.
module tb_sym_align_err_cnt;
  localparam int MAX_DELAY     = 127;
  localparam int DELAY_W       = 7;
  localparam int WIN_LEN       = 64;
  localparam int CNT_W         = 11;
  localparam int LOCK_THRESH   = 0;
  localparam int UNLOCK_THRESH = 32;
  localparam int LOSS_WINDOWS  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sym_align_err_cnt_if #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) bus ();

  sym_align_err_cnt #(
    .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W),
    .LOCK_THRESH(LOCK_THRESH), .UNLOCK_THRESH(UNLOCK_THRESH), .LOSS_WINDOWS(LOSS_WINDOWS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] tx;
    logic [1:0] expAligned;
  } vec_t;

  int nTotal = 0;
  int nBad = 0;

  // reference model state: everything indexed by enables since reset
  int mHist[$];
  int mSyms, mErrs, mBad, mDelay, mErrCount, mAligned;
  bit mLocked, mErrValid, mWrap;

  // channel: rx is tx seen chDelay enables ago, or pure noise
  int chHist[$];
  int chDelay = 0;
  bit chRandom = 1'b0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mHist = {};
    for (int i = 0; i < MAX_DELAY; i++) mHist.push_back(0);
    mSyms = 0; mErrs = 0; mBad = 0; mDelay = 0; mErrCount = 0; mAligned = 0;
    mLocked = 1'b0; mErrValid = 1'b0; mWrap = 1'b0;
  endtask

  task automatic modelStep(input bit rst, input bit en, input int tx, input int rx);
    int tapv;
    mErrValid = 1'b0;
    mWrap = 1'b0;
    if (rst) begin
      modelReset();
      return;
    end
    if (!en) return;
    tapv = (mDelay == 0) ? tx : mHist[mDelay-1];
    mAligned = tapv;
    if (mSyms >= MAX_DELAY) begin
      if (tapv != rx) mErrs++;
      if ((mSyms - MAX_DELAY) % WIN_LEN == WIN_LEN - 1) begin
        mErrCount = mErrs;
        mErrValid = 1'b1;
        if (!mLocked) begin
          if (mErrs <= LOCK_THRESH) begin
            mLocked = 1'b1;
            mBad = 0;
          end else if (mDelay == MAX_DELAY) begin
            mDelay = 0;
            mWrap = 1'b1;
          end else begin
            mDelay++;
          end
        end else begin
          mBad = (mErrs > UNLOCK_THRESH) ? mBad + 1 : 0;
          if (mBad == LOSS_WINDOWS) begin
            mLocked = 1'b0;
            mDelay = 0;
            mBad = 0;
          end
        end
        mErrs = 0;
      end
    end
    mHist.push_front(tx);
    void'(mHist.pop_back());
    mSyms++;
  endtask

  function automatic logic [31:0] dutVec();
    return {9'd0, bus.delay, bus.locked, bus.err_count, bus.err_valid,
            bus.search_wrap, bus.tx_data_aligned};
  endfunction

  function automatic logic [31:0] modelVec();
    return {9'd0, DELAY_W'(mDelay), mLocked, CNT_W'(mErrCount), mErrValid,
            mWrap, 2'(mAligned)};
  endfunction

  task automatic checkOutput();
    checkEq("model_outputs", dutVec(), modelVec());
  endtask

  // called at a negedge; leaves the bench at the following negedge
  task automatic applyStimulus(input bit rst, input bit en, input int tx, input int rx);
    reset = rst;
    bus.clk_en = en;
    bus.tx_data = 2'(tx);
    bus.rx_data = 2'(rx);
    @(posedge clk);
    modelStep(rst, en, tx, rx);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sym(input bit en, input bit flip);
    int tx, rx;
    tx = int'($urandom_range(3, 0));
    if (chRandom) rx = int'($urandom_range(3, 0));
    else rx = (chDelay == 0) ? tx : chHist[chDelay-1];
    if (flip) rx = rx ^ 1;
    applyStimulus(1'b0, en, tx, rx);
    if (en) begin
      chHist.push_front(tx);
      void'(chHist.pop_back());
    end
  endtask

  function automatic int winPos();
    return (mSyms < MAX_DELAY) ? -1 : (mSyms - MAX_DELAY) % WIN_LEN;
  endfunction

  task automatic toWindowStart();
    for (int i = 0; i < WIN_LEN && winPos() != 0; i++) sym(1'b1, 1'b0);
  endtask

  task automatic resetAndFill(input string tag);
    int n;
    applyStimulus(1'b1, 1'b1, 0, 0);
    checkEq({tag, "_zero"}, dutVec(), 32'd0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      sym(1'b1, 1'b0);
      n++;
      if (bus.err_valid) break;
    end
    checkEq({tag, "_first_valid"}, n, MAX_DELAY + WIN_LEN);
  endtask

  vec_t tbl[8];
  int flipPos[10] = '{0, 5, 9, 17, 23, 31, 40, 48, 57, 63};

  initial begin
    int n, gatePulses, validCnt, wrapCnt, lockedSeen;
    bit en;
    bus.clk_en = 1'b0;
    bus.tx_data = 2'd0;
    bus.rx_data = 2'd0;
    for (int i = 0; i < 200; i++) chHist.push_back(0);
    modelReset();

    tbl[0] = '{1'b1, 1'b1, 2'd3, 2'd0};
    tbl[1] = '{1'b0, 1'b1, 2'd2, 2'd2};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 2'd2};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 2'd1};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 2'd3};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 2'd3};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 2'd0};
    tbl[7] = '{1'b0, 1'b1, 2'd1, 2'd1};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, int'(tbl[i].tx), 0);
      checkEq($sformatf("tbl%0d_aligned", i), bus.tx_data_aligned, tbl[i].expAligned);
      checkEq($sformatf("tbl%0d_state", i), {bus.delay, bus.locked, bus.err_valid}, 0);
    end

    // lock on a 52-symbol channel
    applyStimulus(1'b1, 1'b1, 0, 0);
    chDelay = 52;
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      sym(1'b1, 1'b0);
      n++;
      if (bus.locked) break;
    end
    checkEq("lock_enables", n, MAX_DELAY + 53 * WIN_LEN);
    checkEq("lock_delay", bus.delay, 52);
    checkEq("lock_err_count", bus.err_count, 0);
    checkEq("lock_err_valid", bus.err_valid, 1);

    // 10 symbol errors in one window, the last symbol among them
    toWindowStart();
    for (int p = 0; p < WIN_LEN; p++) sym(1'b1, (p inside {flipPos}));
    checkEq("flip_err_count", bus.err_count, 10);
    checkEq("flip_valid", bus.err_valid, 1);
    checkEq("flip_locked", bus.locked, 1);
    for (int p = 0; p < WIN_LEN; p++) sym(1'b1, 1'b0);
    checkEq("clean_err_count", bus.err_count, 0);
    checkEq("clean_locked", bus.locked, 1);

    // long enable gap in the middle of a window
    for (int p = 0; p < 20; p++) sym(1'b1, 1'b0);
    gatePulses = 0;
    for (int c = 0; c < 500; c++) begin
      sym(1'b0, 1'b0);
      gatePulses += int'(bus.err_valid) + int'(bus.search_wrap);
    end
    checkEq("gate_pulses", gatePulses, 0);
    toWindowStart();
    checkEq("gate_window_errs", bus.err_count, 0);

    // channel moves to 60: two bad windows, then search from 0 and relock
    chDelay = 60;
    n = 0;
    for (int i = 0; i < 3 * WIN_LEN; i++) begin
      sym(1'b1, 1'b0);
      n++;
      if (!bus.locked) break;
    end
    checkEq("unlock_enables", n, LOSS_WINDOWS * WIN_LEN);
    checkEq("unlock_delay", bus.delay, 0);
    n = 0;
    for (int i = 0; i < 63 * WIN_LEN; i++) begin
      sym(1'b1, 1'b0);
      n++;
      if (bus.locked) break;
    end
    checkEq("relock_enables", n, 61 * WIN_LEN);
    checkEq("relock_delay", bus.delay, 60);

    // reset while locked, then reset while searching
    for (int p = 0; p < 30; p++) sym(1'b1, 1'b0);
    resetAndFill("rst_locked");
    for (int p = 0; p < 100; p++) sym(1'b1, 1'b0);
    resetAndFill("rst_search");

    // uncorrelated input with random enables: full sweep and one wrap
    applyStimulus(1'b1, 1'b1, 0, 0);
    chRandom = 1'b1;
    validCnt = 0; wrapCnt = 0; lockedSeen = 0;
    n = 0;
    while (n < MAX_DELAY + 130 * WIN_LEN) begin
      en = ($urandom_range(3, 0) != 0);
      sym(en, 1'b0);
      if (en) n++;
      if (bus.err_valid) begin
        validCnt++;
        checkEq("search_step", bus.delay, validCnt % (MAX_DELAY + 1));
      end
      if (bus.search_wrap) begin
        wrapCnt++;
        checkEq("wrap_index", validCnt, MAX_DELAY + 1);
      end
      if (bus.locked) lockedSeen++;
    end
    checkEq("random_windows", validCnt, 130);
    checkEq("random_wraps", wrapCnt, 1);
    checkEq("random_locked", lockedSeen, 0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule
